// File: rtl/ctrl_pkg.sv
// Shared state encoding and default parameter constants for the iteration controller.
package ctrl_pkg;

    localparam int DEF_N_EN     = 3;
    localparam int DEF_ITER_W   = 4;
    localparam int DEF_MAX_ITER = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_STEP  = 3'd3,
        S_CHECK = 3'd4,
        S_FIN   = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

endpackage

// File: rtl/iter_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
// Saturates at all-ones so it can never wrap.
module iter_counter #(
    parameter int W    = 4,
    parameter int TERM = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    // Clear has priority over enable; hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

    assign tc = (count == W'(TERM));

endmodule

// File: rtl/iter_controller.sv
// Iterative-datapath sequencer: loads operands, walks N_EN load-enable stages
// per iteration and checks convergence, ending in done or done+timeout.
module iter_controller
    import ctrl_pkg::*;
#(
    parameter int N_EN     = DEF_N_EN,
    parameter int ITER_W   = DEF_ITER_W,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              complete,
    output logic              en_init,
    output logic              sel,
    output logic [N_EN-1:0]   en_loop,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam int STAGE_W = (N_EN > 1) ? $clog2(N_EN) : 1;
    localparam logic [N_EN-1:0] EN_ONE = N_EN'(1);

    state_t             state;
    logic [STAGE_W-1:0] stage;
    logic               stage_tc;
    logic               stage_clr;
    logic               stage_en;
    logic               iter_tc;
    logic               iter_clr;
    logic               iter_en;

    // Stage index: 0 outside the loop body, stepped 0->1 on entry to the first
    // STEP (from LOAD or CHECK), cleared when the last stage hands off to CHECK
    // or the run ends.
    always_comb begin
        stage_clr = (state == S_INIT)
                 || ((state == S_STEP)  && stage_tc)
                 || ((state == S_CHECK) && (complete || iter_tc));
        stage_en  = (state == S_LOAD) || (state == S_STEP) || (state == S_CHECK);
        iter_clr  = (state == S_IDLE) && start;
        iter_en   = (state == S_CHECK);
    end

    iter_counter #(.W(STAGE_W), .TERM(N_EN - 1)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .clr   (stage_clr),
        .en    (stage_en),
        .count (stage),
        .tc    (stage_tc)
    );

    // Iteration count is cleared as the run is accepted so INIT already reads 0.
    iter_counter #(.W(ITER_W), .TERM(MAX_ITER - 1)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .clr   (iter_clr),
        .en    (iter_en),
        .count (iter_count),
        .tc    (iter_tc)
    );

    // State register with outputs registered alongside the next state, so every
    // output is a pure function of the state/stage being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            en_init <= 1'b0;
            sel     <= 1'b0;
            en_loop <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            en_init <= 1'b0;
            sel     <= 1'b0;
            en_loop <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_INIT;
                        en_init <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_INIT: begin
                    state   <= S_LOAD;
                    sel     <= 1'b1;
                    en_loop <= EN_ONE;
                end
                S_LOAD: begin
                    state   <= S_STEP;
                    en_loop <= EN_ONE << 1;
                end
                S_STEP: begin
                    if (stage_tc) begin
                        state   <= S_CHECK;
                        en_loop <= EN_ONE;
                    end else begin
                        en_loop <= EN_ONE << (stage + 1'b1);
                    end
                end
                S_CHECK: begin
                    if (complete) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else if (iter_tc) begin
                        state   <= S_FAIL;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        state   <= S_STEP;
                        en_loop <= EN_ONE << 1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_controller.sv
// Directed bench for iter_controller with N_EN=3, ITER_W=4, MAX_ITER=4.
module tb_iter_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       complete = 1'b0;
    logic       en_init, sel, busy, done, timeout;
    logic [2:0] en_loop;
    logic [3:0] iter_count;

    int compared   = 0;
    int mismatched = 0;

    iter_controller #(.N_EN(3), .ITER_W(4), .MAX_ITER(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .complete   (complete),
        .en_init    (en_init),
        .sel        (sel),
        .en_loop    (en_loop),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ei, input logic s,
                       input logic [2:0] el, input logic b, input logic d,
                       input logic t, input logic [3:0] ic);
        logic [11:0] obs, exp;
        obs = {en_init, sel, en_loop, busy, done, timeout, iter_count};
        exp = {ei, s, el, b, d, t, ic};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed={ei,sel,en,busy,done,to,ic}=%b_%b_%b_%b_%b_%b_%0d expected=%b_%b_%b_%b_%b_%b_%0d",
                   tag, obs[11], obs[10], obs[9:7], obs[6], obs[5], obs[4], obs[3:0],
                   exp[11], exp[10], exp[9:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Per-cycle invariants: one-hot-or-zero enables, timeout only with done,
    // and nothing active while not busy.
    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            assert (($countones(en_loop) <= 1) && (!timeout || done) &&
                    (busy || !(en_init || sel || (en_loop != 3'b000) || done || timeout)))
            else begin
                mismatched++;
                $error("FAIL invariant observed en_loop=%b busy=%b done=%b timeout=%b en_init=%b sel=%b expected onehot0/timeout->done/idle-quiet",
                       en_loop, busy, done, timeout, en_init, sel);
            end
        end
    end

    initial begin
        // Reset, with start/complete asserted to show reset wins.
        start = 1'b1; complete = 1'b1;
        tick(); tick();
        chk("reset", 0, 0, 3'b000, 0, 0, 0, 4'd0);
        rst = 1'b0; start = 1'b0; complete = 1'b0;
        tick();
        chk("idle", 0, 0, 3'b000, 0, 0, 0, 4'd0);

        // Single-iteration convergence.
        start = 1'b1; tick(); start = 1'b0;
        chk("r1_init", 1, 0, 3'b000, 1, 0, 0, 4'd0);
        tick(); chk("r1_load", 0, 1, 3'b001, 1, 0, 0, 4'd0);
        tick(); chk("r1_step1", 0, 0, 3'b010, 1, 0, 0, 4'd0);
        tick(); chk("r1_step2", 0, 0, 3'b100, 1, 0, 0, 4'd0);
        tick(); chk("r1_check", 0, 0, 3'b001, 1, 0, 0, 4'd0);
        complete = 1'b1; tick(); complete = 1'b0;
        chk("r1_fin", 0, 0, 3'b000, 1, 1, 0, 4'd1);
        tick(); chk("r1_idle", 0, 0, 3'b000, 0, 0, 0, 4'd1);

        // Never converges: four CHECK passes then timeout.
        start = 1'b1; tick(); start = 1'b0;
        chk("r2_init", 1, 0, 3'b000, 1, 0, 0, 4'd0);
        tick(); chk("r2_load", 0, 1, 3'b001, 1, 0, 0, 4'd0);
        for (int p = 0; p < 4; p++) begin
            tick(); chk("r2_step1", 0, 0, 3'b010, 1, 0, 0, 4'(p));
            tick(); chk("r2_step2", 0, 0, 3'b100, 1, 0, 0, 4'(p));
            tick(); chk("r2_check", 0, 0, 3'b001, 1, 0, 0, 4'(p));
        end
        tick(); chk("r2_fail", 0, 0, 3'b000, 1, 1, 1, 4'd4);
        tick(); chk("r2_idle", 0, 0, 3'b000, 0, 0, 0, 4'd4);

        // Converges exactly on the last permitted CHECK.
        start = 1'b1; tick(); start = 1'b0;
        chk("r3_init", 1, 0, 3'b000, 1, 0, 0, 4'd0);
        tick(); chk("r3_load", 0, 1, 3'b001, 1, 0, 0, 4'd0);
        for (int p = 0; p < 4; p++) begin
            tick(); chk("r3_step1", 0, 0, 3'b010, 1, 0, 0, 4'(p));
            tick(); chk("r3_step2", 0, 0, 3'b100, 1, 0, 0, 4'(p));
            tick(); chk("r3_check", 0, 0, 3'b001, 1, 0, 0, 4'(p));
        end
        complete = 1'b1; tick(); complete = 1'b0;
        chk("r3_fin", 0, 0, 3'b000, 1, 1, 0, 4'd4);
        tick(); chk("r3_idle", 0, 0, 3'b000, 0, 0, 0, 4'd4);

        // start mid-run is ignored; start held through FIN restarts from IDLE.
        start = 1'b1; tick(); start = 1'b0;
        chk("r4_init", 1, 0, 3'b000, 1, 0, 0, 4'd0);
        tick(); chk("r4_load", 0, 1, 3'b001, 1, 0, 0, 4'd0);
        start = 1'b1;
        tick(); chk("r4_step1", 0, 0, 3'b010, 1, 0, 0, 4'd0);
        tick(); chk("r4_step2", 0, 0, 3'b100, 1, 0, 0, 4'd0);
        start = 1'b0;
        tick(); chk("r4_check", 0, 0, 3'b001, 1, 0, 0, 4'd0);
        start = 1'b1;
        tick(); chk("r4_step1b", 0, 0, 3'b010, 1, 0, 0, 4'd1);
        tick(); chk("r4_step2b", 0, 0, 3'b100, 1, 0, 0, 4'd1);
        tick(); chk("r4_checkb", 0, 0, 3'b001, 1, 0, 0, 4'd1);
        complete = 1'b1; tick(); complete = 1'b0;
        chk("r4_fin", 0, 0, 3'b000, 1, 1, 0, 4'd2);
        tick(); chk("r4_idle", 0, 0, 3'b000, 0, 0, 0, 4'd2);
        tick(); start = 1'b0;
        chk("r5_init", 1, 0, 3'b000, 1, 0, 0, 4'd0);
        tick(); chk("r5_load", 0, 1, 3'b001, 1, 0, 0, 4'd0);
        tick(); chk("r5_step1", 0, 0, 3'b010, 1, 0, 0, 4'd0);

        // Reset during the second STEP, with start/complete also high.
        tick(); chk("r5_step2", 0, 0, 3'b100, 1, 0, 0, 4'd0);
        rst = 1'b1; start = 1'b1; complete = 1'b1;
        tick(); chk("r5_rst", 0, 0, 3'b000, 0, 0, 0, 4'd0);
        rst = 1'b0; start = 1'b0; complete = 1'b0;
        tick(); chk("r5_idle", 0, 0, 3'b000, 0, 0, 0, 4'd0);

        // Normal run after reset release.
        start = 1'b1; tick(); start = 1'b0;
        chk("r6_init", 1, 0, 3'b000, 1, 0, 0, 4'd0);
        tick(); chk("r6_load", 0, 1, 3'b001, 1, 0, 0, 4'd0);
        tick(); chk("r6_step1", 0, 0, 3'b010, 1, 0, 0, 4'd0);
        tick(); chk("r6_step2", 0, 0, 3'b100, 1, 0, 0, 4'd0);
        tick(); chk("r6_check", 0, 0, 3'b001, 1, 0, 0, 4'd0);
        complete = 1'b1; tick(); complete = 1'b0;
        chk("r6_fin", 0, 0, 3'b000, 1, 1, 0, 4'd1);
        tick(); chk("r6_idle", 0, 0, 3'b000, 0, 0, 0, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/iter_controller.md
ITER_CONTROLLER -- requirements
Module: iter_controller

Interface
REQ-001 SHALL provide parameter N_EN, default 3, meaning number of loop-body load-enable stages (legal range 2..8).
REQ-002 SHALL provide parameter ITER_W, default 4, meaning width of the iteration counter.
REQ-003 SHALL provide parameter MAX_ITER, default 15, meaning maximum CHECK passes before timeout (legal range 1..2^ITER_W-1).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin a run; sampled only in IDLE.
REQ-007 complete  in  1  datapath convergence flag; sampled only in CHECK.
REQ-008 en_init  out  1  load initial operands.
REQ-009 sel  out  1  operand mux select: 1 = fresh operands, 0 = feedback path.
REQ-010 en_loop  out  N_EN  per-stage register load enables.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle end-of-run pulse.
REQ-013 timeout  out  1  one-cycle pulse, coincident with done, when run ended without convergence.
REQ-014 iter_count  out  ITER_W  number of completed CHECK passes in current/last run.

Function
REQ-015 SHALL implement states IDLE, INIT, LOAD, STEP, CHECK, FIN, FAIL; all outputs except iter_count SHALL be Moore-decoded from the state register (and stage index), no input-to-output combinational path.
REQ-016 IDLE: all outputs 0 except iter_count (holds last value); start=1 -> INIT, else stay.
REQ-017 INIT: en_init=1; clears iter_count to 0; unconditional -> LOAD.
REQ-018 LOAD: sel=1, en_loop[0]=1; stage index set to 1; -> STEP.
REQ-019 STEP: en_loop[stage]=1 only; stage increments each cycle; after stage N_EN-1 -> CHECK.
REQ-020 CHECK: sel=0, en_loop[0]=1 (feedback writeback); iter_count increments by 1 on exit.
REQ-021 CHECK exit priority: complete=1 -> FIN; else iter_count==MAX_ITER-1 -> FAIL; else stage index set to 1 -> STEP.
REQ-022 complete=1 in the final permitted CHECK SHALL go to FIN, not FAIL.
REQ-023 FIN: done=1, timeout=0, -> IDLE. FAIL: done=1, timeout=1, -> IDLE.
REQ-024 start outside IDLE SHALL be ignored; start held high in IDLE after FIN/FAIL SHALL begin a new run next cycle.
REQ-025 Latency: start accepted at edge k -> first CHECK occupies cycle k+N_EN+1; each further iteration costs N_EN cycles.
REQ-026 iter_count SHALL never wrap; exactly one en_loop bit or none high in any cycle.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, stage index 0, iter_count 0, all outputs 0, from any state including mid-run.
REQ-028 rst SHALL override start and complete in the same cycle.

Structure
REQ-029 State encoding enum and default parameter constants SHALL live in shared package ctrl_pkg.
REQ-030 Stage index and iteration counters SHALL be one sub-module, iter_counter (synchronous clear, enable, terminal-count flag), instantiated twice.
REQ-031 Target size 120-400 lines of RTL total.

Verification (N_EN=3, ITER_W=4, MAX_ITER=4)
REQ-032 rst 2 cycles, start pulse -> en_init cycle 1, sel+en_loop=001 cycle 2, en_loop=010, 100, CHECK sel=0 en_loop=001 cycle 5; complete=1 there -> done=1 timeout=0 cycle 6, iter_count=1.
REQ-033 complete held 0 -> 4 CHECK passes, then done=1 timeout=1, iter_count=4, busy falls next cycle.
REQ-034 complete=1 only on 4th CHECK -> done=1 timeout=0, iter_count=4.
REQ-035 start pulsed during STEP and CHECK -> no effect on sequence; start held high through FIN -> new run, iter_count cleared in INIT.
REQ-036 rst asserted during second STEP -> next cycle IDLE, all outputs 0, iter_count 0; start after release runs normally.
REQ-037 Every cycle assertion: popcount(en_loop)<=1, timeout implies done, busy==0 iff IDLE.
